// File: rtl/switch_input_capture_if.sv
// Handshake bundle between the control unit/board pins and the IN-instruction capture block.
// master drives the request, step, switches and key; slave returns halt and captured data.
interface switch_input_capture_if #(
   parameter int DATA_WIDTH = 18
);
   logic                  inp_req;
   logic                  step;
   logic [DATA_WIDTH-1:0] sw;
   logic                  key_n;
   logic                  halt;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  busy;

   modport master (
      output inp_req, step, sw, key_n,
      input  halt, data_out, data_valid, busy
   );

   modport slave (
      input  inp_req, step, sw, key_n,
      output halt, data_out, data_valid, busy
   );
endinterface

// File: rtl/switch_input_capture.sv
// IN-instruction input path: halts the CPU clock, waits for a debounced confirm press, captures the switches.
// Two-cycle synchroniser latency, then DEBOUNCE_CYCLES stable cycles before capture; no backpressure.
module switch_input_capture #(
   parameter int DATA_WIDTH      = 18,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic                  CLOCK_50,
   input logic                  reset,
   switch_input_capture_if.slave cap
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RELEASE,
      WAIT_PRESS,
      DEBOUNCE,
      CAPTURE,
      DONE
   } state_t;

   state_t                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] sw_s1_q;
   logic [DATA_WIDTH-1:0] sw_s2_q;
   logic                  key_s1_q;
   logic                  key_s2_q;
   logic                  halt_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  data_valid_q;
   logic                  busy_q;
   logic                  key_p;
   logic [CNT_W-1:0]      cnt_inc_d;

   assign key_p     = ~key_s2_q;
   assign cnt_inc_d = cnt_q + CNT_W'(1);

   // Outputs are registered alongside the state so they always describe the state being entered.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sw_s1_q      <= '0;
         sw_s2_q      <= '0;
         key_s1_q     <= 1'b0;
         key_s2_q     <= 1'b0;
         halt_q       <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         sw_s1_q      <= cap.sw;
         sw_s2_q      <= sw_s1_q;
         key_s1_q     <= cap.key_n;
         key_s2_q     <= key_s1_q;
         data_valid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (cap.inp_req) begin
                  state_q <= key_p ? WAIT_RELEASE : WAIT_PRESS;
                  cnt_q   <= '0;
                  halt_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end

            // A key still held from the previous capture must be seen released before it can confirm again.
            WAIT_RELEASE: begin
               if (!cap.inp_req) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  halt_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (key_p) begin
                  cnt_q <= '0;
               end else if (cnt_q == CNT_TERM) begin
                  state_q <= WAIT_PRESS;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            WAIT_PRESS: begin
               if (!cap.inp_req) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  halt_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (key_p) begin
                  state_q <= DEBOUNCE;
                  cnt_q   <= '0;
               end
            end

            DEBOUNCE: begin
               if (!cap.inp_req) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  halt_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (!key_p) begin
                  state_q <= WAIT_PRESS;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_TERM) begin
                  state_q      <= CAPTURE;
                  cnt_q        <= '0;
                  data_out_q   <= sw_s2_q;
                  data_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            CAPTURE: begin
               state_q <= DONE;
               cnt_q   <= '0;
               halt_q  <= 1'b0;
            end

            // The request level may still be high from the same instruction; only step ends it.
            DONE: begin
               if (cap.step) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               halt_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cap.halt       = halt_q;
   assign cap.data_out   = data_out_q;
   assign cap.data_valid = data_valid_q;
   assign cap.busy       = busy_q;

endmodule
